// File: rtl/alu_pkg.sv
// Shared ALU operation codes, execute-unit FSM states and small decode helpers.
// The ALU decoder imports this too, so the codes have a single source.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0100,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SLL  = 4'b1010,
    OP_SRL  = 4'b1011,
    OP_SRA  = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_exec_serial_shifter.sv
// One-bit-per-cycle shifter: working register, down-counter and fill-bit select.
// The first step is taken while loading, so busy drops after amount-1 further cycles.
module serial_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dir,
  input  logic             arith,
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   amount,
  output logic             busy,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                             input logic right,
                                             input logic ar);
    if (right) return {ar & v[WIDTH-1], v[WIDTH-1:1]};
    else       return {v[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    if (load) begin
      work_d  = step1(value, dir, arith);
      cnt_d   = amount - SHW'(1);
      dir_d   = dir;
      arith_d = arith;
    end else if (cnt_q != '0) begin
      work_d = step1(work_q, dir_q, arith_q);
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign out  = work_q;

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifts, valid/ready
// handshakes on both sides; result/zero/illegal registered and held in DONE.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  alu_op_e          op;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] alu_val;
  logic             alu_ill;
  logic             sh_load, sh_dir, sh_arith, sh_busy;
  logic [WIDTH-1:0] sh_out;

  assign op       = alu_op_e'(ALUControl);
  assign amt      = b[SHW-1:0];
  assign sh_load  = in_valid && (state_q == S_IDLE) && is_shift(op) && (amt != '0);
  assign sh_dir   = (op != OP_SLL);
  assign sh_arith = (op == OP_SRA);

  // Shifts by zero complete here and simply pass a through.
  always_comb begin
    alu_val = '0;
    alu_ill = 1'b0;
    case (op)
      OP_AND:  alu_val = a & b;
      OP_OR:   alu_val = a | b;
      OP_ADD:  alu_val = a + b;
      OP_SUB:  alu_val = a - b;
      OP_XOR:  alu_val = a ^ b;
      OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_val = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: alu_val = a;
      default: alu_ill = 1'b1;
    endcase
  end

  serial_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load   (sh_load),
    .dir    (sh_dir),
    .arith  (sh_arith),
    .value  (a),
    .amount (amt),
    .busy   (sh_busy),
    .out    (sh_out)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (sh_load) begin
            state_d = S_SHIFT;
          end else begin
            result_d    = alu_val;
            zero_d      = (alu_val == '0);
            illegal_d   = alu_ill;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        if (!sh_busy) begin
          result_d    = sh_out;
          zero_d      = (sh_out == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed cases then random ops against an arithmetic reference model.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result straight from the operation definitions, latency from the shift amount.
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(y[4:0]);
    ill = 1'b0;
    lat = 1;
    r   = 32'd0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0100: r = x ^ y;
      4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: r = (x < y) ? 32'd1 : 32'd0;
      4'b1010: begin r = x << sh; lat = 1 + sh; end
      4'b1011: begin r = x >> sh; lat = 1 + sh; end
      4'b1100: begin r = 32'($signed(x) >>> sh); lat = 1 + sh; end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int hold);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          lat;
    model(op, x, y, er, ei, el);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; ALUControl = op; a = x; b = y; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; ALUControl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(el));
    check("result", result, er);
    check("zero", 32'(zero), 32'(er == 32'd0));
    check("illegal", 32'(illegal), 32'(ei));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, er);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] codes [12];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0111,
              4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1111, 4'b0011};
    reset = 1'b1; in_valid = 1'b0; ALUControl = 4'd0; a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    do_op(4'b0010, 32'd7, 32'd5, 0);
    do_op(4'b0110, 32'd5, 32'd5, 0);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'b1000, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'b1100, 32'h8000_0000, 32'd31, 0);
    do_op(4'b1011, 32'h8000_0000, 32'd31, 0);
    do_op(4'b1010, 32'd1, 32'd0, 0);
    do_op(4'b1111, 32'd3, 32'd4, 0);
    do_op(4'b0100, 32'h0000_00F0, 32'h0000_00FF, 5);
    do_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
    do_op(4'b0001, 32'hF000_0000, 32'h0000_000F, 0);
    do_op(4'b1100, 32'h7000_0001, 32'd1, 2);

    // Reset in the 10th cycle of an sll by 20.
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 4'b1010; a = 32'h0000_0003; b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", result, 32'd0);
    do_op(4'b0010, 32'd1, 32'd1, 0);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      op = codes[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) op = 4'($urandom);
      do_op(op, $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
